// File: rtl/opb_snapshot_simulink2ppc.sv
// OPB slave exposing a snapshot register that fabric logic loads through a capture strobe,
// plus status (new-data flag, saturating overrun count) and control (freeze, clear overrun).
module opb_snapshot_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000F00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01000FFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_valid,
  output logic        user_ready,
  output logic        user_overrun
);

  // Bus widths are fixed at 32 and the family string is informational only.
  localparam int unused_width_sum = C_OPB_AWIDTH + C_OPB_DWIDTH;
  localparam bit unused_family    = (C_FAMILY == "virtex5");

  logic [31:0] data_q, data_d;
  logic        new_data_q, new_data_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        freeze_q, freeze_d;
  logic        ack_q, ack_d;
  logic        rnw_q, rnw_d;
  logic [1:0]  idx_q, idx_d;

  logic [31:0] wdata;
  logic [31:0] rd_mux;
  logic [1:0]  addr_idx;
  logic        hit, new_hit, accept, wr_ctrl, clr_ovr, data_rd_ack;
  logic        unused_bits;

  // Leftmost OPB bit is the register MSB, so a plain vector copy performs the bit reversal.
  assign wdata    = OPB_DBus;
  assign addr_idx = OPB_ABus[28:29];

  assign hit         = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign new_hit     = hit && !ack_q;
  assign accept      = user_valid && !freeze_q;
  assign wr_ctrl     = new_hit && !OPB_RNW && (addr_idx == 2'd2) && OPB_BE[3];
  assign clr_ovr     = wr_ctrl && wdata[0];
  assign data_rd_ack = ack_q && rnw_q && (idx_q == 2'd0);

  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:2], unused_family,
                         unused_width_sum[0]};

  always_comb begin
    data_d     = data_q;
    new_data_d = new_data_q;
    ovr_d      = ovr_q;
    freeze_d   = freeze_q;
    ack_d      = new_hit;
    rnw_d      = OPB_RNW;
    idx_d      = addr_idx;

    if (accept) begin
      data_d = user_data_in;
    end
    // A capture landing in the same cycle as a DATA-read ack keeps the flag set.
    if (data_rd_ack) begin
      new_data_d = 1'b0;
    end
    if (accept) begin
      new_data_d = 1'b1;
    end

    if (accept && new_data_q && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
    if (clr_ovr) begin
      ovr_d = 8'd0;
    end

    if (wr_ctrl) begin
      freeze_d = wdata[1];
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      data_q     <= '0;
      new_data_q <= 1'b0;
      ovr_q      <= '0;
      freeze_q   <= 1'b0;
      ack_q      <= 1'b0;
      rnw_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      data_q     <= data_d;
      new_data_q <= new_data_d;
      ovr_q      <= ovr_d;
      freeze_q   <= freeze_d;
      ack_q      <= ack_d;
      rnw_q      <= rnw_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (idx_q)
      2'd0:    rd_mux = data_q;
      2'd1:    rd_mux = {15'd0, freeze_q, ovr_q, 7'd0, new_data_q};
      2'd2:    rd_mux = {30'd0, freeze_q, 1'b0};
      default: rd_mux = '0;
    endcase
  end

  assign Sl_DBus      = (ack_q && rnw_q) ? rd_mux : '0;
  assign Sl_xferAck   = ack_q;
  assign Sl_errAck    = 1'b0;
  assign Sl_retry     = 1'b0;
  assign Sl_toutSup   = 1'b0;
  assign user_ready   = !freeze_q;
  assign user_overrun = (ovr_q != 8'd0);

endmodule

// File: tb/tb_opb_snapshot_simulink2ppc.sv
// Directed bench for the OPB snapshot slave: bus reads/writes, captures, overrun and freeze.
module tb_opb_snapshot_simulink2ppc;

  localparam logic [31:0] A_DATA = 32'h01000F00;
  localparam logic [31:0] A_STAT = 32'h01000F04;
  localparam logic [31:0] A_CTRL = 32'h01000F08;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        xfer_ack, err_ack, retry, tout_sup;
  logic [31:0] user_data = '0;
  logic        user_valid = 1'b0;
  logic        user_ready, user_overrun;

  int checks = 0;
  int errors = 0;

  opb_snapshot_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(xfer_ack), .Sl_errAck(err_ack), .Sl_retry(retry), .Sl_toutSup(tout_sup),
    .user_data_in(user_data), .user_valid(user_valid), .user_ready(user_ready),
    .user_overrun(user_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; sel = 1'b0; user_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic capture(input logic [31:0] d);
    user_valid = 1'b1; user_data = d;
    tick;
    user_valid = 1'b0;
  endtask

  task automatic opb_read(input logic [31:0] addr, output logic [31:0] data, output logic acked);
    sel = 1'b1; rnw = 1'b1; abus = addr; be = 4'hF;
    tick;
    acked = xfer_ack; data = sl_dbus;
    sel = 1'b0; rnw = 1'b0; abus = '0;
    tick;
  endtask

  task automatic opb_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] bes,
                           output logic acked);
    sel = 1'b1; rnw = 1'b0; abus = addr; dbus = d; be = bes;
    tick;
    acked = xfer_ack;
    sel = 1'b0; dbus = '0; abus = '0;
    tick;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic a;
    do_reset;
    checks++; if (sl_dbus !== 32'h0) begin errors++; $display("FAIL reset_dbus got %h expected 00000000", sl_dbus); end
    checks++; if (xfer_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", xfer_ack); end
    checks++; if ({err_ack, retry, tout_sup} !== 3'b000) begin errors++; $display("FAIL reset_consts got %b expected 000", {err_ack, retry, tout_sup}); end
    checks++; if ({user_ready, user_overrun} !== 2'b10) begin errors++; $display("FAIL reset_user got %b expected 10", {user_ready, user_overrun}); end
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h expected 00000000", d); end
    $display("test_reset: status=%h", d);
  endtask

  task automatic test_capture_read;
    logic [31:0] d; logic a;
    do_reset;
    capture(32'hDEADBEEF);
    sel = 1'b1; rnw = 1'b1; abus = A_DATA; be = 4'hF;
    tick;
    checks++; if (xfer_ack !== 1'b1) begin errors++; $display("FAIL read_ack got %b expected 1", xfer_ack); end
    checks++; if (sl_dbus !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h expected deadbeef", sl_dbus); end
    sel = 1'b0; rnw = 1'b0; abus = '0;
    tick;
    checks++; if (xfer_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %b expected 0", xfer_ack); end
    checks++; if (sl_dbus !== 32'h0) begin errors++; $display("FAIL dbus_idle got %h expected 00000000", sl_dbus); end
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_after_read got %h expected 00000000", d); end
    $display("test_capture_read: status=%h", d);
  endtask

  task automatic test_overrun;
    logic [31:0] d; logic a;
    do_reset;
    for (int i = 0; i < 3; i++) capture(32'(i + 1));
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h00000201) begin errors++; $display("FAIL status_3cap got %h expected 00000201", d); end
    for (int i = 0; i < 297; i++) capture(32'(i));
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h0000FF01) begin errors++; $display("FAIL status_sat got %h expected 0000ff01", d); end
    checks++; if (user_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b expected 1", user_overrun); end
    opb_write(A_CTRL, 32'h1, 4'hF, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL ctrl_write_ack got %b expected 1", a); end
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL status_cleared got %h expected 00000001", d); end
    checks++; if (user_overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared got %b expected 0", user_overrun); end
    // clear write coincident with an overrun increment
    capture(32'h55);
    sel = 1'b1; rnw = 1'b0; abus = A_CTRL; dbus = 32'h1; be = 4'hF;
    user_valid = 1'b1; user_data = 32'h66;
    tick;
    user_valid = 1'b0; sel = 1'b0; dbus = '0;
    tick;
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL clear_wins got %h expected 00000001", d); end
    // byte lane 3 disabled: control write ignored
    capture(32'h77);
    opb_write(A_CTRL, 32'h3, 4'b1110, a);
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h00000101) begin errors++; $display("FAIL be_gated got %h expected 00000101", d); end
    checks++; if (user_ready !== 1'b1) begin errors++; $display("FAIL be_gated_ready got %b expected 1", user_ready); end
    $display("test_overrun: final status=%h", d);
  endtask

  task automatic test_freeze;
    logic [31:0] d; logic a;
    do_reset;
    capture(32'h11112222);
    opb_read(A_DATA, d, a);
    opb_write(A_CTRL, 32'h2, 4'hF, a);
    checks++; if (user_ready !== 1'b0) begin errors++; $display("FAIL frozen_ready got %b expected 0", user_ready); end
    capture(32'h12345678);
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h00010000) begin errors++; $display("FAIL frozen_status got %h expected 00010000", d); end
    opb_read(A_DATA, d, a);
    checks++; if (d !== 32'h11112222) begin errors++; $display("FAIL frozen_data got %h expected 11112222", d); end
    opb_read(A_CTRL, d, a);
    checks++; if (d !== 32'h00000002) begin errors++; $display("FAIL ctrl_readback got %h expected 00000002", d); end
    opb_write(A_CTRL, 32'h0, 4'hF, a);
    checks++; if (user_ready !== 1'b1) begin errors++; $display("FAIL unfrozen_ready got %b expected 1", user_ready); end
    $display("test_freeze: ctrl=%h", d);
  endtask

  task automatic test_coincident_read;
    logic [31:0] d; logic a;
    do_reset;
    capture(32'h0BADF00D);
    sel = 1'b1; rnw = 1'b1; abus = A_DATA; be = 4'hF;
    tick;
    user_valid = 1'b1; user_data = 32'hA5A5A5A5;
    checks++; if (xfer_ack !== 1'b1) begin errors++; $display("FAIL coinc_ack got %b expected 1", xfer_ack); end
    checks++; if (sl_dbus !== 32'h0BADF00D) begin errors++; $display("FAIL coinc_old_data got %h expected 0badf00d", sl_dbus); end
    sel = 1'b0; rnw = 1'b0; abus = '0;
    tick;
    user_valid = 1'b0;
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h00000101) begin errors++; $display("FAIL coinc_status got %h expected 00000101", d); end
    opb_read(A_DATA, d, a);
    checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL coinc_new_data got %h expected a5a5a5a5", d); end
    $display("test_coincident_read: data=%h", d);
  endtask

  task automatic test_back_to_back;
    logic [5:0] acks;
    logic [5:0] exp_acks;
    logic [31:0] d; logic a;
    do_reset;
    exp_acks = 6'b010101;
    sel = 1'b1; rnw = 1'b1; abus = A_STAT; be = 4'hF;
    for (int j = 0; j < 6; j++) begin
      tick;
      acks[j] = xfer_ack;
      if (j == 4) sel = 1'b0;
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (acks[j] !== exp_acks[j]) begin
        errors++; $display("FAIL b2b_cycle%0d got %b expected %b", j + 2, acks[j], exp_acks[j]);
      end
    end
    sel = 1'b1; abus = 32'h01001003;
    tick;
    checks++; if (xfer_ack !== 1'b0) begin errors++; $display("FAIL oor_high_ack got %b expected 0", xfer_ack); end
    checks++; if (sl_dbus !== 32'h0) begin errors++; $display("FAIL oor_high_dbus got %h expected 00000000", sl_dbus); end
    sel = 1'b0; tick;
    opb_read(32'h01000EFC, d, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL oor_low_ack got %b expected 0", a); end
    $display("test_back_to_back: acks=%b", acks);
  endtask

  task automatic test_reset_abort;
    logic [31:0] d; logic a;
    do_reset;
    capture(32'hCAFEF00D);
    capture(32'hCAFEF00E);
    opb_write(A_CTRL, 32'h2, 4'hF, a);
    sel = 1'b1; rnw = 1'b1; abus = A_DATA; rst_n = 1'b0;
    tick;
    rst_n = 1'b1; sel = 1'b0; rnw = 1'b0;
    checks++; if (xfer_ack !== 1'b0) begin errors++; $display("FAIL abort_ack0 got %b expected 0", xfer_ack); end
    tick;
    checks++; if (xfer_ack !== 1'b0) begin errors++; $display("FAIL abort_ack1 got %b expected 0", xfer_ack); end
    checks++; if ({user_ready, user_overrun} !== 2'b10) begin errors++; $display("FAIL abort_user got %b expected 10", {user_ready, user_overrun}); end
    opb_read(A_DATA, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_data got %h expected 00000000", d); end
    opb_read(A_STAT, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_status got %h expected 00000000", d); end
    opb_read(A_CTRL, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_ctrl got %h expected 00000000", d); end
    $display("test_reset_abort: ctrl=%h", d);
  endtask

  initial begin
    test_reset;
    test_capture_read;
    test_overrun;
    test_freeze;
    test_coincident_read;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_snapshot_simulink2ppc.md
OPB_SNAPSHOT_SIMULINK2PPC -- requirements
Module: opb_snapshot_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01000F00, first byte address of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h01000FFF, last byte address of the slave window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, OPB address width; C_OPB_DWIDTH, default 32, OPB data width; C_FAMILY, default "virtex5", target family (informational).
REQ-004 SHALL have port OPB_Clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port OPB_Rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports OPB_ABus in [0:31], OPB_BE in [0:3], OPB_DBus in [0:31], OPB_RNW in 1, OPB_select in 1, OPB_seqAddr in 1, standard OPB master-side signals.
REQ-007 SHALL have ports Sl_DBus out [0:31], Sl_xferAck out 1, Sl_errAck out 1, Sl_retry out 1, Sl_toutSup out 1, standard OPB slave responses.
REQ-008 SHALL have port user_data_in  in  [31:0]  fabric-side data word.
REQ-009 SHALL have port user_valid  in  1  one-cycle capture strobe for user_data_in.
REQ-010 SHALL have port user_ready  out  1  high when captures are accepted (not frozen).
REQ-011 SHALL have port user_overrun  out  1  high while overrun count is nonzero.

Function
REQ-012 SHALL map bit order with Sl_DBus[0] = register bit 31 … Sl_DBus[31] = bit 0, and the same for OPB_DBus.
REQ-013 SHALL decode a hit when OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = OPB_ABus[28:29].
REQ-014 SHALL implement this register map: idx0 DATA (RO, last captured word); idx1 STATUS (RO: bit0 new_data, bits[15:8] overrun_cnt, bit16 freeze); idx2 CONTROL (RW: bit0 clear_overrun self-clearing, bit1 freeze); idx3 reads 0.
REQ-015 SHALL assert Sl_xferAck for exactly one cycle, in the cycle after a hit is first seen with Sl_xferAck low, and SHALL drive no ack for a non-hit.
REQ-016 SHALL, with OPB_select held high after an ack, insert one idle cycle before the next ack (ack, gap, ack cadence); OPB_seqAddr SHALL be ignored.
REQ-017 SHALL drive Sl_DBus with read data only in the ack cycle of a read (OPB_RNW=1), otherwise all zeros.
REQ-018 SHALL sample writes at the hit cycle; CONTROL writes SHALL honour OPB_BE[3] for bits[7:0] and ignore other lanes; writes to idx0/1/3 SHALL be acked and discarded.
REQ-019 SHALL, on user_valid=1 with freeze=0, load DATA <= user_data_in and set new_data next cycle; user_valid with freeze=1 SHALL be ignored entirely.
REQ-020 SHALL, on an accepted capture while new_data=1, increment overrun_cnt, saturating at 255.
REQ-021 SHALL clear new_data in the ack cycle of a DATA read; a STATUS read SHALL NOT clear it.
REQ-022 SHALL, when a DATA-read ack and an accepted capture coincide, return the old DATA and leave new_data=1 (capture wins).
REQ-023 SHALL, when a clear_overrun write and an overrun increment coincide, leave overrun_cnt=0 (clear wins).
REQ-024 SHALL drive Sl_errAck, Sl_retry and Sl_toutSup constant 0; user_ready = ~freeze; user_overrun = (overrun_cnt != 0).

Reset
REQ-025 SHALL, while OPB_Rst_n=0 at a clock edge, clear DATA, new_data, overrun_cnt, CONTROL and the ack register; Sl_DBus=0, Sl_xferAck=0, user_ready=1, user_overrun=0.
REQ-026 SHALL abort any pending hit on reset: no Sl_xferAck in the first cycle after OPB_Rst_n returns high.

Verification
REQ-027 SHALL cover: reset, user_valid with user_data_in=32'hDEADBEEF, read idx0 -> Sl_DBus=32'hDEADBEEF one cycle after select, one-cycle ack, then STATUS bit0=0.
REQ-028 SHALL cover: three captures without a read -> STATUS=32'h00000201; 300 captures -> overrun_cnt=255, user_overrun=1.
REQ-029 SHALL cover: write CONTROL=32'h2, then user_valid with 32'h12345678 -> DATA unchanged, user_ready=0, STATUS bit16=1.
REQ-030 SHALL cover: DATA-read ack coincident with capture of 32'hA5A5A5A5 -> returns old word, next STATUS bit0=1, next DATA read=32'hA5A5A5A5.
REQ-031 SHALL cover: select held high 6 cycles on idx1 -> acks on cycles 2, 4, 6 only; address C_HIGHADDR+4 -> no ack, Sl_DBus=0.
REQ-032 SHALL cover: OPB_Rst_n low during hit cycle -> no ack after release, all registers 0.
